// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: sequences a clock-gate enable with wake settle and idle timeout for shared requesters
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               FORCE_ON,
  output logic               CLK_EN,
  output logic [NUM_REQ-1:0] ACK,
  output logic               GATE_ON,
  output logic [7:0]         WAKE_EVENTS
);
  typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic any_req;
  assign any_req = (|REQ) | FORCE_ON;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      OFF: if (any_req) begin
        state_nx = WAKE;
        cnt_nx   = '0;
      end
      WAKE: begin
        cnt_nx   = cnt + 1'b1;
        state_nx = (cnt == CNT_W'(WAKE_CYCLES - 1)) ? ON : WAKE;
      end
      ON: if (!any_req) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      IDLE: begin
        cnt_nx   = any_req ? cnt : cnt + 1'b1;
        state_nx = any_req ? ON : (cnt == CNT_W'(IDLE_CYCLES - 1)) ? OFF : IDLE;
      end
      default: state_nx = OFF;
    endcase
  end
  // Outputs are registered from next_state so they align with the state they describe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= OFF;
      cnt         <= '0;
      CLK_EN      <= 1'b0;
      ACK         <= '0;
      GATE_ON     <= 1'b0;
      WAKE_EVENTS <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      CLK_EN      <= state_nx != OFF;
      ACK         <= (state_nx == ON) ? REQ : '0;
      GATE_ON     <= (state_nx == ON) || (state_nx == IDLE);
      WAKE_EVENTS <= (state == OFF && any_req && WAKE_EVENTS != 8'hff) ? WAKE_EVENTS + 8'd1 : WAKE_EVENTS;
    end
  end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: randomized and directed checks against a countdown-based reference model
module tb_clk_gate_ctrl;
  localparam int N = 4, WK = 2, ID = 8;
  logic CLK = 0, RST = 0, FORCE_ON = 0;
  logic [N-1:0] REQ = '0;
  logic CLK_EN, GATE_ON;
  logic [N-1:0] ACK;
  logic [7:0] WAKE_EVENTS;
  int errors = 0, checks = 0;
  int m_mode = 0, m_left = 0, m_ev = 0;
  clk_gate_ctrl #(.NUM_REQ(N), .WAKE_CYCLES(WK), .IDLE_CYCLES(ID), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .FORCE_ON(FORCE_ON),
    .CLK_EN(CLK_EN), .ACK(ACK), .GATE_ON(GATE_ON), .WAKE_EVENTS(WAKE_EVENTS)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // mode: 0 gate closed, 1 settling, 2 granted, 3 idle countdown
  task automatic model_edge();
    bit any = (|REQ) | FORCE_ON;
    if (m_mode == 0) begin
      if (any) begin m_mode = 1; m_left = WK; if (m_ev < 255) m_ev++; end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end else if (m_mode == 2) begin
      if (!any) begin m_mode = 3; m_left = ID; end
    end else if (any) m_mode = 2;
    else begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  endtask
  task automatic check_all(input logic [N-1:0] req_at_edge);
    chk("clk_en", CLK_EN, m_mode != 0);
    chk("ack", ACK, m_mode == 2 ? req_at_edge : '0);
    chk("gate_on", GATE_ON, m_mode >= 2);
    chk("wake_events", WAKE_EVENTS, m_ev);
  endtask
  task automatic tick();
    logic [N-1:0] r;
    @(posedge CLK);
    r = REQ;
    model_edge();
    @(negedge CLK);
    check_all(r);
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic async_reset();
    #2 RST = 1;
    #1 m_mode = 0; m_ev = 0;
    check_all('0);
    @(negedge CLK);
    check_all('0);
    RST = 0;
  endtask
  initial begin
    #2 RST = 1;
    #2 check_all('0);
    @(negedge CLK) RST = 0;
    ticks(2);
    REQ = 4'b0001;
    ticks(5);
    chk("ack_after_wake", ACK, 4'b0001);
    REQ = 4'b0011; tick();
    REQ = 4'b0010; tick();
    REQ = 4'b0110; tick();
    chk("overlap_ack", ACK, 4'b0110);
    REQ = '0;
    ticks(6);
    REQ = 4'b0100;
    ticks(3);
    chk("idle_rearm_ev", WAKE_EVENTS, 8'd1);
    REQ = '0;
    ticks(12);
    chk("idle_closed", CLK_EN, 1'b0);
    FORCE_ON = 1; ticks(6);
    chk("force_gate_on", GATE_ON, 1'b1);
    chk("force_no_ack", ACK, '0);
    FORCE_ON = 0; ticks(12);
    for (int w = 0; w < 300; w++) begin
      REQ = 4'(1 << (w % N)); ticks(3);
      REQ = '0; ticks(ID + 2);
    end
    chk("ev_saturated", WAKE_EVENTS, 8'hff);
    async_reset();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 5) == 0) REQ = $urandom_range(0, 1) ? 4'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) FORCE_ON = ~FORCE_ON;
      tick();
    end
    REQ = '0; FORCE_ON = 0; ticks(15);
    REQ = 4'b1000; tick();
    async_reset();
    ticks(4);
    chk("restart_wake", ACK, 4'b1000);
    ticks(2);
    async_reset();
    ticks(4);
    chk("restart_on", GATE_ON, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
